// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS mul/div unit owning HI/LO, with the ID-stage HI/LO interlock
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             ID_UsesHiLo,
  output logic             Busy,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic sa, sb, ge;
  logic [WIDTH-1:0] ma, mb, diff, quo, rem;
  logic [WIDTH:0] msum, top;
  logic [2*WIDTH-1:0] mstep, dstep, prod;
  always_comb begin
    sa = !Op[0] && A[WIDTH-1];
    sb = !Op[0] && B[WIDTH-1];
    ma = sa ? -A : A;
    mb = sb ? -B : B;
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mstep = {msum, acc_q[WIDTH-1:1]};
    top = acc_q[2*WIDTH-1:WIDTH-1];
    ge = top >= {1'b0, opd_q};
    diff = top[WIDTH-1:0] - opd_q;
    dstep = {ge ? diff : top[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
    prod = neg_q ? -acc_q : acc_q;
    quo = dz_q ? '1 : neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opd_d = opd_q;
    hi_d = hi_q;
    lo_d = lo_q;
    div_d = div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    if (state_q == IDLE) begin
      if (Start) begin
        state_d = RUN;
        cnt_d = CNT_W'(WIDTH);
        div_d = Op[1];
        neg_d = sa ^ sb;
        rneg_d = sa;
        dz_d = Op[1] && B == '0;
        acc_d = {{WIDTH{1'b0}}, Op[1] ? ma : mb};
        opd_d = Op[1] ? mb : ma;
      end else begin
        hi_d = WriteHi ? WriteData : hi_q;
        lo_d = WriteLo ? WriteData : lo_q;
      end
    end else if (state_q == RUN) begin
      acc_d = div_q ? dstep : mstep;
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == 1 ? FIX : RUN;
    end else begin
      state_d = IDLE;
      hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = div_q ? quo : prod[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opd_q <= opd_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_q <= div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
    end
  end
  assign Busy = state_q != IDLE;
  assign Stall = ID_UsesHiLo && (Busy || Start);
  assign Hi = hi_q;
  assign Lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed HI/LO results
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Start = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [31:0] A = '0, B = '0, WriteData = '0;
  logic WriteHi = 1'b0, WriteLo = 1'b0, ID_UsesHiLo = 1'b0;
  logic Busy, Stall;
  logic [31:0] Hi, Lo;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
    .ID_UsesHiLo(ID_UsesHiLo), .Busy(Busy), .Stall(Stall), .Hi(Hi), .Lo(Lo)
  );
  always @(posedge clk) if (!reset && Start && Busy) $error("FAIL start_while_busy");
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wr, input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clk);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    WriteHi = wr;
    WriteLo = wr;
    WriteData = 32'h5555_5555;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, n, 33);
    check({tag, "_hi"}, Hi, eh);
    check({tag, "_lo"}, Lo, el);
    WriteHi = 1'b0;
    WriteLo = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ID_UsesHiLo = 1'b1;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("idle_stall", Stall, 0);
    ID_UsesHiLo = 1'b0;
    run_op("mult", 2'b00, 32'd3, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_zero", 2'b10, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu_zero", 2'b11, 32'h8000_0001, 32'd0, 1'b0, 32'h8000_0001, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    run_op("start_wr", 2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    @(negedge clk);
    Start = 1'b1;
    Op = 2'b00;
    A = 32'd7;
    B = 32'hFFFF_FFFA;
    ID_UsesHiLo = 1'b1;
    n = 0;
    #1;
    while (Stall && n < 100) begin
      n++;
      @(negedge clk);
      Start = 1'b0;
      #1;
    end
    check("stall_len", n, 34);
    check("stall_busy", Busy, 0);
    check("stall_hi", Hi, 32'hFFFF_FFFF);
    check("stall_lo", Lo, 32'hFFFF_FFD6);
    ID_UsesHiLo = 1'b0;
    @(negedge clk);
    WriteLo = 1'b1;
    WriteData = 32'h1234;
    @(negedge clk);
    WriteLo = 1'b0;
    check("mtlo", Lo, 32'h1234);
    Start = 1'b1;
    Op = 2'b00;
    A = 32'd5;
    B = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", Busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_hi", Hi, 0);
    check("abort_lo", Lo, 0);
    WriteHi = 1'b1;
    WriteData = 32'hABCD;
    @(negedge clk);
    WriteHi = 1'b0;
    check("mthi", Hi, 32'hABCD);
    check("mthi_lo", Lo, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit owning the architectural HI/LO registers of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a WIDTH-cycle shift-add or restoring-divide sequence, with one extra sign-fix cycle. It produces the interlock Stall that holds IF/ID while an ID-stage instruction touches HI/LO before the result is ready. This Stall is ORed with the hazard unit's Stall at the top level.

Parameters:
WIDTH, 32, operand, HI and LO width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
Start  input  1  EX-stage mul/div issue, single-cycle pulse
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start
A  input  WIDTH  rs operand (multiplicand / dividend)
B  input  WIDTH  rt operand (multiplier / divisor)
WriteHi  input  1  EX-stage MTHI
WriteLo  input  1  EX-stage MTLO
WriteData  input  WIDTH  data for MTHI/MTLO
ID_UsesHiLo  input  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
Busy  output  1  sequence in progress
Stall  output  1  interlock to PC/IF-ID write enables
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE; Hi, Lo, counter and internal accumulators are cleared to 0; Busy=0. A reset during RUN or FIX aborts the operation with no HI/LO update.
- States:
  - IDLE -> RUN on Start. Operand magnitudes are latched: absolute value for signed ops, raw value for unsigned ops. Result signs are recorded. Counter is set to WIDTH.
  - RUN: one bit per cycle. MUL uses a 2*WIDTH shift-add. DIV uses a restoring shift-subtract. Counter decrements each cycle. RUN -> FIX when counter reaches 1 after its decrement.
  - FIX: apply signs. MUL: negate the 2*WIDTH product if the operand signs differ. DIV: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - FIX -> IDLE. At this edge Hi/Lo are written (MUL: Hi=upper half, Lo=lower half; DIV: Lo=quotient, Hi=remainder) and Busy falls.
- Latency: Start sampled at edge 0. Busy=1 for exactly WIDTH+1 cycles (WIDTH RUN + 1 FIX). Hi/Lo hold the new result in the first cycle with Busy=0.
- Busy is registered: high from the cycle after Start through the FIX cycle.
- Stall = ID_UsesHiLo && (Busy || Start). It is combinational and covers the same-cycle case of EX issuing while ID reads HI/LO.
- Start while Busy: ignored, state unchanged. This cannot occur given Stall and is flagged as a bench assertion error.
- WriteHi/WriteLo in IDLE update the register at the next edge.
- WriteHi/WriteLo while Busy: ignored.
- Start together with WriteHi/WriteLo: Start wins and the write is dropped.
- Divide by zero (B=0, DIV or DIVU): Lo = all ones, Hi = A (raw dividend), for both signed and unsigned. Sign fix is skipped. Busy timing is unchanged.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): Lo=0x80000000, Hi=0.
- Arithmetic: the product is 2*WIDTH bits with no truncation. All negation is two's complement in WIDTH or 2*WIDTH bits.

Test Plan:
- MULT A=3, B=0xFFFFFFFC -> Busy high for exactly 33 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFF4.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIVU 100/7 -> Lo=14, Hi=2. DIV 0xFFFFFFF9 (-7)/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV 5/0 -> Lo=0xFFFFFFFF, Hi=5. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- ID_UsesHiLo asserted in the same cycle as Start and held -> Stall=1 for 34 cycles (issue cycle + 33 Busy); Stall=0 in the first cycle Hi/Lo show the result.
- Assert reset at RUN cycle 10 of a MULT after a prior MTLO of 0x1234 -> next cycle Busy=0, Hi=Lo=0. A subsequent MTHI 0xABCD -> Hi=0xABCD at the next edge.
